pipe_ctrl: RTL and testbench
============================

// Module: pipe_ctrl
// PURPOSE
//  Central stall/flush controller for the 5-stage pipeline (PC, IF/ID, ID/EX, EX/MEM, MEM/WB).
//  Arbitrates stall requests from the IF, ID, EX and MEM stages and the commit-stage exception.
//  Drives per-register hold/bubble vectors and the PC redirect.
//  Drains an in-flight AXI instruction fetch after a flush; flags hung stalls via a watchdog.
// PARAMETERS
//  STALL_TIMEOUT  1024  consecutive cycles any stall request may stay high before hang_err sets
//  CNT_W          32    width of the per-source stall-cycle performance counters
// PORTS
//  clk            in   1      clock
//  rst            in   1      reset, synchronous, active-high
//  stallreq_if    in   1      fetch not ready (icache/AXI miss)
//  stallreq_id    in   1      load-use hazard in ID
//  stallreq_ex    in   1      multi-cycle mult/div busy
//  stallreq_mem   in   1      data access not complete
//  exception      in   1      exception/ERET committed in MEM this cycle
//  excep_new_pc   in   32     redirect target (vector or EPC)
//  if_axi_busy    in   1      fetch AXI read outstanding
//  if_resp_valid  in   1      fetch AXI read data beat returned (RVALID&RREADY)
//  pc_stall       out  1      hold PC
//  stall          out  4      hold mask: [0] IF/ID, [1] ID/EX, [2] EX/MEM, [3] MEM/WB
//  bubble         out  4      load NOP into the register, same bit order
//  flush          out  1      clear all pipeline registers (to the exception input of each)
//  pc_redirect    out  1      load redirect_pc into PC this cycle
//  redirect_pc    out  32     redirect target
//  if_discard     out  1      drop the returning fetch data (do not write IF/ID)
//  hang_err       out  1      sticky watchdog error
//  cnt_if/id/ex/mem out CNT_W stall cycles charged to each source
// BEHAVIOUR
//  Reset: all outputs 0, counters 0, state IDLE, watchdog count 0.
//  Stall/flush outputs are combinational from the inputs and state (zero latency).
//  Priority: exception > mem > ex > id > if. Only the highest-priority request is charged.
//  Encoding {pc_stall, stall, bubble}:
//   none: 0,0000,0000 | if: 1,0001,0000 | id: 1,0001,0010
//   ex: 1,0011,0100   | mem: 1,0111,1000
//  exception in IDLE: flush=1, pc_redirect=1, redirect_pc=excep_new_pc, stall=0, pc_stall=0.
//   Stall requests in the same cycle are ignored and not charged.
//   If if_axi_busy=1 in that cycle, next state is DRAIN; otherwise stay IDLE.
//  DRAIN: pc_stall=1, if_discard=1, stall=0001, bubble=0000.
//   On the cycle if_resp_valid=1, if_discard=1 still applies; next state is IDLE.
//   A fetch that returns in the exception cycle itself also takes the IDLE path, with if_discard=1 in that cycle.
//  exception while in DRAIN: flush and pc_redirect assert again with the new target; stay in DRAIN.
//  Counters: +1 per charged cycle; saturate at all-ones, no wrap.
//  Watchdog: the count increments while any stallreq_* is high and clears when all are low.
//   When the count reaches STALL_TIMEOUT, hang_err sets and stays set until rst.
//   DRAIN cycles do not count.
//  rst mid-DRAIN: return to IDLE, if_discard drops next cycle. Exception FSM states: IDLE, DRAIN.
// STRUCTURE
//  defines.vh: stall/bubble encoding constants (STALL_NONE/IF/ID/EX/MEM), FSM state codes,
//   STALL_BUS width macro.
//  Sub-module: stall_watchdog (saturating counter + sticky hang_err), one instance.
//  The priority encoder, FSM and perf counters stay in pipe_ctrl.
// TESTING
//  stallreq_id=1 for 3 cycles -> pc_stall=1, stall=0001, bubble=0010 each cycle; cnt_id=3.
//  stallreq_if=1, stallreq_ex=1, stallreq_mem=1 together -> stall=0111, bubble=1000;
//   only cnt_mem increments.
//  exception=1, excep_new_pc=0xBFC00380, if_axi_busy=0 -> flush=1, pc_redirect=1,
//   redirect_pc=0xBFC00380 that cycle; IDLE next cycle.
//  exception with if_axi_busy=1, if_resp_valid after 4 cycles -> if_discard=1 for those 4 cycles
//   plus the response cycle; normal fetch resumes after.
//  Second exception (target 0x80000180) during DRAIN -> redirect_pc=0x80000180, stays DRAIN
//   until the response.
//  STALL_TIMEOUT=8, stallreq_ex held 8 cycles -> hang_err=1 and stays 1 after the request drops;
//   rst clears it.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared constants for the pipeline stall/flush controller.
// Contents:
//   STALL_BUS    number of inter-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB)
//   stall_enc_t  packed {pc_stall, stall[3:0], bubble[3:0]} control word
//   STALL_*      control words for each arbitration outcome
//   ST_*         exception FSM state codes
//   SRC_*        index of each stall source in the per-source counter array
package pipe_ctrl_pkg;

    localparam int STALL_BUS = 4;
    localparam int ENC_W     = 1 + 2 * STALL_BUS;

    typedef logic [ENC_W-1:0] stall_enc_t;

    // {pc_stall, stall[3:0], bubble[3:0]}
    localparam stall_enc_t STALL_NONE  = 9'b0_0000_0000;
    localparam stall_enc_t STALL_IF    = 9'b1_0001_0000;
    localparam stall_enc_t STALL_ID    = 9'b1_0001_0010;
    localparam stall_enc_t STALL_EX    = 9'b1_0011_0100;
    localparam stall_enc_t STALL_MEM   = 9'b1_0111_1000;
    // While draining, PC and IF/ID hold so the discarded beat cannot land anywhere.
    localparam stall_enc_t STALL_DRAIN = 9'b1_0001_0000;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_DRAIN = 1'b1;

    localparam int SRC_IF  = 0;
    localparam int SRC_ID  = 1;
    localparam int SRC_EX  = 2;
    localparam int SRC_MEM = 3;

endpackage

// File: rtl/pipe_ctrl_stall_watchdog.sv
// Stall watchdog: counts consecutive cycles with any stall request raised and
// sets a sticky error once the count reaches STALL_TIMEOUT.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   req_i         any stall request high this cycle
//   hold_i        freeze the count (fetch drain in progress)
//   hang_err_o    sticky timeout flag, cleared only by rst
module pipe_ctrl_stall_watchdog #(
    parameter int STALL_TIMEOUT = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic req_i,
    input  logic hold_i,
    output logic hang_err_o
);

    localparam int CW = $clog2(STALL_TIMEOUT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STALL_TIMEOUT);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          hang_q, hang_d;

    always_comb begin
        cnt_d = cnt_q;
        if (!req_i) begin
            cnt_d = '0;
        end else if (!hold_i && (cnt_q != LIMIT)) begin
            cnt_d = cnt_q + CW'(1);
        end
        hang_d = hang_q | (cnt_d == LIMIT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            hang_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            hang_q <= hang_d;
        end
    end

    assign hang_err_o = hang_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Central stall/flush controller for the 5-stage pipeline.
// Arbitrates stall requests (exception > mem > ex > id > if), drives the
// per-register hold/bubble masks and PC redirect, drains an in-flight fetch
// after a flush, counts stall cycles per source and runs a hang watchdog.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   stallreq_if/id/ex/mem          per-stage stall requests
//   exception, excep_new_pc        committed exception/ERET and its target
//   if_axi_busy, if_resp_valid     fetch AXI read outstanding / beat returned
//   pc_stall, stall, bubble        PC hold, register hold mask, NOP-insert mask
//   flush, pc_redirect, redirect_pc pipeline clear and PC load
//   if_discard                     drop the returning fetch beat
//   hang_err                       sticky watchdog error
//   cnt_if/id/ex/mem               saturating stall-cycle counters
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int STALL_TIMEOUT = 1024,
    parameter int CNT_W         = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stallreq_if,
    input  logic                 stallreq_id,
    input  logic                 stallreq_ex,
    input  logic                 stallreq_mem,
    input  logic                 exception,
    input  logic [31:0]          excep_new_pc,
    input  logic                 if_axi_busy,
    input  logic                 if_resp_valid,
    output logic                 pc_stall,
    output logic [STALL_BUS-1:0] stall,
    output logic [STALL_BUS-1:0] bubble,
    output logic                 flush,
    output logic                 pc_redirect,
    output logic [31:0]          redirect_pc,
    output logic                 if_discard,
    output logic                 hang_err,
    output logic [CNT_W-1:0]     cnt_if,
    output logic [CNT_W-1:0]     cnt_id,
    output logic [CNT_W-1:0]     cnt_ex,
    output logic [CNT_W-1:0]     cnt_mem
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    logic [0:0]     state_q, state_d;
    stall_enc_t     enc;
    logic [3:0]     charge;
    logic [CNT_W-1:0] cnt_q [4];

    always_comb begin
        state_d     = state_q;
        enc         = STALL_NONE;
        flush       = 1'b0;
        pc_redirect = 1'b0;
        redirect_pc = '0;
        if_discard  = 1'b0;
        charge      = '0;
        if (state_q == ST_IDLE) begin
            if (exception) begin
                // Flush wins outright; same-cycle stall requests are moot.
                flush       = 1'b1;
                pc_redirect = 1'b1;
                redirect_pc = excep_new_pc;
                if_discard  = if_resp_valid;
                if (if_axi_busy && !if_resp_valid) begin
                    state_d = ST_DRAIN;
                end
            end else if (stallreq_mem) begin
                enc             = STALL_MEM;
                charge[SRC_MEM] = 1'b1;
            end else if (stallreq_ex) begin
                enc            = STALL_EX;
                charge[SRC_EX] = 1'b1;
            end else if (stallreq_id) begin
                enc            = STALL_ID;
                charge[SRC_ID] = 1'b1;
            end else if (stallreq_if) begin
                enc            = STALL_IF;
                charge[SRC_IF] = 1'b1;
            end
        end else begin
            enc        = STALL_DRAIN;
            if_discard = 1'b1;
            if (exception) begin
                flush       = 1'b1;
                pc_redirect = 1'b1;
                redirect_pc = excep_new_pc;
            end
            // The stale beat is the only thing outstanding; once it lands we are clean.
            if (if_resp_valid) begin
                state_d = ST_IDLE;
            end
        end
    end

    assign {pc_stall, stall, bubble} = enc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
        end else begin
            state_q <= state_d;
            for (int i = 0; i < 4; i++) begin
                if (charge[i]) cnt_q[i] <= sat_inc(cnt_q[i]);
            end
        end
    end

    assign cnt_if  = cnt_q[SRC_IF];
    assign cnt_id  = cnt_q[SRC_ID];
    assign cnt_ex  = cnt_q[SRC_EX];
    assign cnt_mem = cnt_q[SRC_MEM];

    pipe_ctrl_stall_watchdog #(
        .STALL_TIMEOUT(STALL_TIMEOUT)
    ) u_watchdog (
        .clk        (clk),
        .rst        (rst),
        .req_i      (stallreq_if | stallreq_id | stallreq_ex | stallreq_mem),
        .hold_i     (state_q == ST_DRAIN),
        .hang_err_o (hang_err)
    );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios plus a randomized run
// checked against a cycle-level behavioural model.
module tb_pipe_ctrl;

    localparam int TO = 8;
    localparam int CW = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stallreq_if = 0, stallreq_id = 0, stallreq_ex = 0, stallreq_mem = 0;
    logic        exception = 0;
    logic [31:0] excep_new_pc = '0;
    logic        if_axi_busy = 0, if_resp_valid = 0;
    logic        pc_stall, flush, pc_redirect, if_discard, hang_err;
    logic [3:0]  stall, bubble;
    logic [31:0] redirect_pc;
    logic [CW-1:0] cnt_if, cnt_id, cnt_ex, cnt_mem;

    always #5 clk = ~clk;

    pipe_ctrl #(.STALL_TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .stallreq_if(stallreq_if), .stallreq_id(stallreq_id),
        .stallreq_ex(stallreq_ex), .stallreq_mem(stallreq_mem),
        .exception(exception), .excep_new_pc(excep_new_pc),
        .if_axi_busy(if_axi_busy), .if_resp_valid(if_resp_valid),
        .pc_stall(pc_stall), .stall(stall), .bubble(bubble),
        .flush(flush), .pc_redirect(pc_redirect), .redirect_pc(redirect_pc),
        .if_discard(if_discard), .hang_err(hang_err),
        .cnt_if(cnt_if), .cnt_id(cnt_id), .cnt_ex(cnt_ex), .cnt_mem(cnt_mem)
    );

    int n_chk = 0;
    int n_fail = 0;

    // ---------------- behavioural reference model ----------------
    bit          m_drain, m_hang;
    int          m_cnt [4];
    int          m_wd;
    logic [8:0]  e_enc;        // {pc_stall, stall, bubble}
    logic        e_flush, e_redir, e_disc;
    logic [31:0] e_rpc;

    function automatic int top_level();
        int lvl = 0;
        if (stallreq_if)  lvl = 1;
        if (stallreq_id)  lvl = 2;
        if (stallreq_ex)  lvl = 3;
        if (stallreq_mem) lvl = 4;
        return lvl;
    endfunction

    task automatic model_eval();
        int lvl = top_level();
        logic [3:0] s, b;
        e_enc = '0; e_flush = 0; e_redir = 0; e_disc = 0; e_rpc = '0;
        if (m_drain) begin
            e_enc = {1'b1, 4'b0001, 4'b0000};
            e_disc = 1;
            if (exception) begin e_flush = 1; e_redir = 1; e_rpc = excep_new_pc; end
        end else if (exception) begin
            e_flush = 1; e_redir = 1; e_rpc = excep_new_pc; e_disc = if_resp_valid;
        end else if (lvl > 0) begin
            // stages strictly younger than the stalling one hold; the stalling one gets a NOP
            s = (lvl <= 2) ? 4'd1 : 4'((1 << (lvl - 1)) - 1);
            b = (lvl >= 2) ? 4'(1 << (lvl - 1)) : 4'd0;
            e_enc = {1'b1, s, b};
        end
    endtask

    task automatic model_commit();
        int lvl = top_level();
        if (rst) begin
            m_drain = 0; m_hang = 0; m_wd = 0;
            for (int i = 0; i < 4; i++) m_cnt[i] = 0;
        end else begin
            if (!m_drain && !exception && lvl > 0 && m_cnt[lvl-1] < CMAX) m_cnt[lvl-1]++;
            if (lvl == 0) m_wd = 0;
            else if (!m_drain && m_wd < TO) m_wd++;
            if (m_wd >= TO) m_hang = 1;
            if (m_drain) m_drain = !if_resp_valid;
            else         m_drain = exception && if_axi_busy && !if_resp_valid;
        end
    endtask

    task automatic clk_edge();
        @(posedge clk);
        model_commit();
        #1;
    endtask

    task automatic drive(input bit rif, rid, rex, rmem, exc, input logic [31:0] pc,
                         input bit busy, resp);
        stallreq_if = rif; stallreq_id = rid; stallreq_ex = rex; stallreq_mem = rmem;
        exception = exc; excep_new_pc = pc; if_axi_busy = busy; if_resp_valid = resp;
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 0, 32'h0, 0, 0);
        rst = 1;
        clk_edge(); clk_edge();
        rst = 0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        do_reset();
        @(negedge clk);
        n_chk++;
        if ({pc_stall, stall, bubble, flush, pc_redirect, if_discard, hang_err} !== 13'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b required 0",
                     {pc_stall, stall, bubble, flush, pc_redirect, if_discard, hang_err});
        end
        n_chk++;
        if (redirect_pc !== 32'h0) begin
            n_fail++; $display("FAIL reset_rpc: got %h required 0", redirect_pc);
        end
        n_chk++;
        if ({cnt_if, cnt_id, cnt_ex, cnt_mem} !== '0) begin
            n_fail++; $display("FAIL reset_cnt: got %h required 0", {cnt_if, cnt_id, cnt_ex, cnt_mem});
        end
        clk_edge();
    endtask

    task automatic test_id_stall();
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 0, 0, 0, 32'h0, 0, 0);
            @(negedge clk);
            n_chk++;
            if ({pc_stall, stall, bubble} !== 9'b1_0001_0010) begin
                n_fail++; $display("FAIL id_enc[%0d]: got %b required 100010010", i, {pc_stall, stall, bubble});
            end
            clk_edge();
        end
        drive(0, 0, 0, 0, 0, 32'h0, 0, 0);
        n_chk++;
        if (cnt_id !== 4'd3) begin
            n_fail++; $display("FAIL id_count: got %0d required 3", cnt_id);
        end
        clk_edge();
    endtask

    task automatic test_priority();
        for (int i = 0; i < 2; i++) begin
            drive(1, 0, 1, 1, 0, 32'h0, 0, 0);
            @(negedge clk);
            n_chk++;
            if ({stall, bubble} !== 8'b0111_1000) begin
                n_fail++; $display("FAIL prio_mem[%0d]: got %b required 01111000", i, {stall, bubble});
            end
            clk_edge();
        end
        drive(1, 0, 0, 0, 0, 32'h0, 0, 0);
        @(negedge clk);
        n_chk++;
        if ({pc_stall, stall, bubble} !== 9'b1_0001_0000) begin
            n_fail++; $display("FAIL prio_if: got %b required 100010000", {pc_stall, stall, bubble});
        end
        clk_edge();
        drive(1, 1, 1, 0, 0, 32'h0, 0, 0);
        @(negedge clk);
        n_chk++;
        if ({pc_stall, stall, bubble} !== 9'b1_0011_0100) begin
            n_fail++; $display("FAIL prio_ex: got %b required 100110100", {pc_stall, stall, bubble});
        end
        clk_edge();
        drive(0, 0, 0, 0, 0, 32'h0, 0, 0);
        n_chk++;
        if ({cnt_if, cnt_id, cnt_ex, cnt_mem} !== {4'd1, 4'd3, 4'd1, 4'd2}) begin
            n_fail++; $display("FAIL prio_counts: got if=%0d id=%0d ex=%0d mem=%0d required 1 3 1 2",
                               cnt_if, cnt_id, cnt_ex, cnt_mem);
        end
        clk_edge();
    endtask

    task automatic test_exception_idle();
        drive(0, 1, 0, 0, 1, 32'hBFC00380, 0, 0);
        @(negedge clk);
        n_chk++;
        if ({flush, pc_redirect, pc_stall, stall} !== 7'b1100000 || redirect_pc !== 32'hBFC00380) begin
            n_fail++; $display("FAIL exc_idle: got flush=%b redir=%b pcs=%b stall=%b pc=%h required 1 1 0 0000 bfc00380",
                               flush, pc_redirect, pc_stall, stall, redirect_pc);
        end
        clk_edge();
        drive(0, 0, 0, 0, 0, 32'h0, 0, 0);
        @(negedge clk);
        n_chk++;
        if ({flush, if_discard, pc_stall} !== 3'b000 || cnt_id !== 4'd3) begin
            n_fail++; $display("FAIL exc_after: got flush=%b disc=%b pcs=%b cnt_id=%0d required 0 0 0 3",
                               flush, if_discard, pc_stall, cnt_id);
        end
        clk_edge();
    endtask

    task automatic test_drain();
        drive(0, 0, 0, 0, 1, 32'h80000000, 1, 0);
        @(negedge clk);
        n_chk++;
        if (if_discard !== 1'b0 || flush !== 1'b1) begin
            n_fail++; $display("FAIL drain_entry: got disc=%b flush=%b required 0 1", if_discard, flush);
        end
        clk_edge();
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 0, 0, 0, 32'h0, 1, 0);
            @(negedge clk);
            n_chk++;
            if ({if_discard, pc_stall, stall, bubble} !== 10'b11_0001_0000) begin
                n_fail++; $display("FAIL drain_wait[%0d]: got %b required 1100010000", i,
                                   {if_discard, pc_stall, stall, bubble});
            end
            clk_edge();
        end
        drive(0, 0, 0, 0, 0, 32'h0, 1, 1);
        @(negedge clk);
        n_chk++;
        if (if_discard !== 1'b1) begin
            n_fail++; $display("FAIL drain_resp: got disc=%b required 1", if_discard);
        end
        clk_edge();
        drive(0, 0, 0, 0, 0, 32'h0, 0, 0);
        @(negedge clk);
        n_chk++;
        if ({if_discard, pc_stall} !== 2'b00) begin
            n_fail++; $display("FAIL drain_exit: got disc=%b pcs=%b required 0 0", if_discard, pc_stall);
        end
        clk_edge();
    endtask

    task automatic test_drain_reexception();
        drive(0, 0, 0, 0, 1, 32'hBFC00380, 1, 0);
        clk_edge();
        drive(0, 0, 0, 0, 1, 32'h80000180, 1, 0);
        @(negedge clk);
        n_chk++;
        if ({flush, pc_redirect, if_discard} !== 3'b111 || redirect_pc !== 32'h80000180) begin
            n_fail++; $display("FAIL reexc: got flush=%b redir=%b disc=%b pc=%h required 1 1 1 80000180",
                               flush, pc_redirect, if_discard, redirect_pc);
        end
        clk_edge();
        for (int i = 0; i < 2; i++) begin
            drive(0, 0, 0, 0, 0, 32'h0, 1, 0);
            @(negedge clk);
            n_chk++;
            if ({if_discard, pc_redirect} !== 2'b10) begin
                n_fail++; $display("FAIL reexc_stay[%0d]: got disc=%b redir=%b required 1 0", i, if_discard, pc_redirect);
            end
            clk_edge();
        end
        drive(0, 0, 0, 0, 0, 32'h0, 1, 1);
        clk_edge();
        drive(0, 0, 0, 0, 0, 32'h0, 0, 0);
        @(negedge clk);
        n_chk++;
        if (if_discard !== 1'b0) begin
            n_fail++; $display("FAIL reexc_exit: got disc=%b required 0", if_discard);
        end
        clk_edge();
    endtask

    task automatic test_exc_resp_same_cycle();
        drive(0, 0, 0, 0, 1, 32'h80000180, 1, 1);
        @(negedge clk);
        n_chk++;
        if (if_discard !== 1'b1) begin
            n_fail++; $display("FAIL same_cycle_disc: got %b required 1", if_discard);
        end
        clk_edge();
        drive(0, 0, 0, 0, 0, 32'h0, 0, 0);
        @(negedge clk);
        n_chk++;
        if ({if_discard, pc_stall} !== 2'b00) begin
            n_fail++; $display("FAIL same_cycle_idle: got disc=%b pcs=%b required 0 0", if_discard, pc_stall);
        end
        clk_edge();
    endtask

    task automatic test_rst_mid_drain();
        drive(0, 0, 0, 0, 1, 32'h80000180, 1, 0);
        clk_edge();
        drive(0, 0, 0, 0, 0, 32'h0, 1, 0);
        rst = 1;
        @(negedge clk);
        n_chk++;
        if (if_discard !== 1'b1) begin
            n_fail++; $display("FAIL rst_drain_hold: got disc=%b required 1", if_discard);
        end
        clk_edge();
        rst = 0;
        @(negedge clk);
        n_chk++;
        if ({if_discard, pc_stall} !== 2'b00) begin
            n_fail++; $display("FAIL rst_drain_idle: got disc=%b pcs=%b required 0 0", if_discard, pc_stall);
        end
        clk_edge();
    endtask

    task automatic test_watchdog();
        do_reset();
        for (int i = 0; i < 5; i++) begin drive(0, 0, 1, 0, 0, 32'h0, 0, 0); clk_edge(); end
        drive(0, 0, 0, 0, 0, 32'h0, 0, 0); clk_edge();
        for (int i = 0; i < 5; i++) begin drive(0, 0, 1, 0, 0, 32'h0, 0, 0); clk_edge(); end
        n_chk++;
        if (hang_err !== 1'b0) begin
            n_fail++; $display("FAIL wd_cleared_gap: got %b required 0", hang_err);
        end
        drive(0, 0, 0, 0, 0, 32'h0, 0, 0); clk_edge();
        for (int i = 0; i < 7; i++) begin drive(0, 0, 1, 0, 0, 32'h0, 0, 0); clk_edge(); end
        n_chk++;
        if (hang_err !== 1'b0) begin
            n_fail++; $display("FAIL wd_early: got %b required 0 after 7 cycles", hang_err);
        end
        clk_edge();
        n_chk++;
        if (hang_err !== 1'b1) begin
            n_fail++; $display("FAIL wd_fire: got %b required 1 after 8 cycles", hang_err);
        end
        drive(0, 0, 0, 0, 0, 32'h0, 0, 0);
        for (int i = 0; i < 3; i++) clk_edge();
        n_chk++;
        if (hang_err !== 1'b1) begin
            n_fail++; $display("FAIL wd_sticky: got %b required 1", hang_err);
        end
        do_reset();
        n_chk++;
        if (hang_err !== 1'b0) begin
            n_fail++; $display("FAIL wd_rst: got %b required 0", hang_err);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < CMAX + 5; i++) begin drive(0, 0, 0, 1, 0, 32'h0, 0, 0); clk_edge(); end
        drive(0, 0, 0, 0, 0, 32'h0, 0, 0);
        n_chk++;
        if (cnt_mem !== 4'(CMAX)) begin
            n_fail++; $display("FAIL cnt_saturate: got %0d required %0d", cnt_mem, CMAX);
        end
        clk_edge();
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 9) < 3, $urandom_range(0, 9) < 2, $urandom_range(0, 9) < 2,
                  $urandom_range(0, 9) < 2, $urandom_range(0, 11) == 0, $urandom,
                  $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0);
            @(negedge clk);
            model_eval();
            n_chk++;
            if ({pc_stall, stall, bubble, flush, pc_redirect, if_discard} !== {e_enc, e_flush, e_redir, e_disc}
                || redirect_pc !== e_rpc) begin
                n_fail++; $display("FAIL rand_comb[%0d]: got %b/%h required %b/%h", i,
                                   {pc_stall, stall, bubble, flush, pc_redirect, if_discard}, redirect_pc,
                                   {e_enc, e_flush, e_redir, e_disc}, e_rpc);
            end
            clk_edge();
            n_chk++;
            if (cnt_if !== 4'(m_cnt[0]) || cnt_id !== 4'(m_cnt[1]) || cnt_ex !== 4'(m_cnt[2])
                || cnt_mem !== 4'(m_cnt[3]) || hang_err !== m_hang) begin
                n_fail++; $display("FAIL rand_state[%0d]: got %0d %0d %0d %0d h=%b required %0d %0d %0d %0d h=%b", i,
                                   cnt_if, cnt_id, cnt_ex, cnt_mem, hang_err,
                                   m_cnt[0], m_cnt[1], m_cnt[2], m_cnt[3], m_hang);
            end
        end
    endtask

    initial begin
        test_reset();
        test_id_stall();
        test_priority();
        test_exception_idle();
        test_drain();
        test_drain_reexception();
        test_exc_resp_same_cycle();
        test_rst_mid_drain();
        test_watchdog();
        test_saturation();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
